// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - shared ALU/RV32I encodings and immediate-format selects for the decode stage
package decode_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [1:0] {
      IMM_I     = 2'd0,
      IMM_SHAMT = 2'd1,
      IMM_U     = 2'd2
   } imm_sel_e;

   // funct3 mapping shared by OP and OP-IMM when funct7 is the base encoding
   function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - fetch, register-file, writeback and execute-slot signals of the decode stage
interface decode_stage_if;
   logic [31:0] instr_i;
   logic [31:0] pc_i;
   logic        instr_valid_i;
   logic        ready_o;
   logic        flush_i;
   logic [4:0]  rs1_addr_o;
   logic [4:0]  rs2_addr_o;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic        wb_we_i;
   logic [4:0]  wb_rd_i;
   logic [31:0] wb_data_i;
   logic        ex_valid_o;
   logic        ex_ready_i;
   logic [31:0] alu_op1_o;
   logic [31:0] alu_op2_o;
   logic [3:0]  alu_opcode_o;
   logic [4:0]  rd_o;
   logic        rd_we_o;
   logic [31:0] pc_o;
   logic        illegal_o;

   modport slave (
      input  instr_i, pc_i, instr_valid_i, flush_i, rs1_data_i, rs2_data_i,
             wb_we_i, wb_rd_i, wb_data_i, ex_ready_i,
      output ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, alu_op1_o, alu_op2_o,
             alu_opcode_o, rd_o, rd_we_o, pc_o, illegal_o
   );

   modport master (
      output instr_i, pc_i, instr_valid_i, flush_i, rs1_data_i, rs2_data_i,
             wb_we_i, wb_rd_i, wb_data_i, ex_ready_i,
      input  ready_o, rs1_addr_o, rs2_addr_o, ex_valid_o, alu_op1_o, alu_op2_o,
             alu_opcode_o, rd_o, rd_we_o, pc_o, illegal_o
   );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational I / shamt / U immediate selection
module imm_gen
   import decode_stage_pkg::*;
(
   input  logic [19:0] instr_hi,
   input  imm_sel_e    sel,
   output logic [31:0] imm
);

   // instr_hi carries instr[31:12]; the low 12 bits never feed an immediate here
   always_comb begin
      imm = 32'd0;
      case (sel)
         IMM_I:     imm = {{20{instr_hi[19]}}, instr_hi[19:8]};
         IMM_SHAMT: imm = {27'd0, instr_hi[12:8]};
         IMM_U:     imm = {instr_hi, 12'd0};
         default:   imm = 32'd0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode/issue into a single valid/ready execute slot with writeback forwarding
module decode_stage #(
   parameter bit FORWARD_EN = 1'b1
) (
   input logic           clk_i,
   input logic           rst_i,
   decode_stage_if.slave bus
);
   import decode_stage_pkg::*;

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   logic [4:0] rs1, rs2, rd;

   assign opcode = bus.instr_i[6:0];
   assign rd     = bus.instr_i[11:7];
   assign f3     = bus.instr_i[14:12];
   assign rs1    = bus.instr_i[19:15];
   assign rs2    = bus.instr_i[24:20];
   assign f7     = bus.instr_i[31:25];

   assign bus.rs1_addr_o = rs1;
   assign bus.rs2_addr_o = rs2;

   logic [31:0] src1, src2;
   logic        fwd1, fwd2;

   assign fwd1 = FORWARD_EN && bus.wb_we_i && (bus.wb_rd_i == rs1) && (rs1 != 5'd0);
   assign fwd2 = FORWARD_EN && bus.wb_we_i && (bus.wb_rd_i == rs2) && (rs2 != 5'd0);
   assign src1 = fwd1 ? bus.wb_data_i : bus.rs1_data_i;
   assign src2 = fwd2 ? bus.wb_data_i : bus.rs2_data_i;

   imm_sel_e    imm_sel;
   logic [31:0] imm;

   assign imm_sel = (opcode == OPC_LUI || opcode == OPC_AUIPC) ? IMM_U :
                    (f3 == 3'b001 || f3 == 3'b101)              ? IMM_SHAMT : IMM_I;

   imm_gen u_imm_gen (
      .instr_hi (bus.instr_i[31:12]),
      .sel      (imm_sel),
      .imm      (imm)
   );

   logic        legal;
   alu_op_e     dec_op;
   logic [31:0] dec_op1, dec_op2;

   always_comb begin
      legal   = 1'b0;
      dec_op  = ALU_ADD;
      dec_op1 = 32'd0;
      dec_op2 = 32'd0;
      case (opcode)
         OPC_OP: begin
            dec_op1 = src1;
            dec_op2 = src2;
            if (f7 == F7_BASE) begin
               legal  = 1'b1;
               dec_op = f3_to_alu(f3);
            end else if (f7 == F7_ALT && f3 == 3'b000) begin
               legal  = 1'b1;
               dec_op = ALU_SUB;
            end else if (f7 == F7_ALT && f3 == 3'b101) begin
               legal  = 1'b1;
               dec_op = ALU_SRA;
            end
         end
         OPC_OP_IMM: begin
            dec_op1 = src1;
            dec_op2 = imm;
            case (f3)
               3'b001: begin
                  legal  = (f7 == F7_BASE);
                  dec_op = ALU_SLL;
               end
               3'b101: begin
                  legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                  dec_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               end
               default: begin
                  legal  = 1'b1;
                  dec_op = f3_to_alu(f3);
               end
            endcase
         end
         OPC_LUI: begin
            legal   = 1'b1;
            dec_op2 = imm;
         end
         OPC_AUIPC: begin
            legal   = 1'b1;
            dec_op1 = bus.pc_i;
            dec_op2 = imm;
         end
         default: legal = 1'b0;
      endcase
      // Illegal encodings of every kind issue as a harmless ADD of zeros
      if (!legal) begin
         dec_op  = ALU_ADD;
         dec_op1 = 32'd0;
         dec_op2 = 32'd0;
      end
   end

   logic        ex_valid_q, rd_we_q, illegal_q;
   logic [31:0] op1_q, op2_q, pc_q;
   logic [3:0]  opc_q;
   logic [4:0]  rd_q;
   logic        ready, accept;

   assign ready  = !ex_valid_q || bus.ex_ready_i;
   assign accept = bus.instr_valid_i && ready && !bus.flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_valid_q <= 1'b0;
         op1_q      <= 32'd0;
         op2_q      <= 32'd0;
         opc_q      <= 4'd0;
         rd_q       <= 5'd0;
         rd_we_q    <= 1'b0;
         pc_q       <= 32'd0;
         illegal_q  <= 1'b0;
      end else if (bus.flush_i) begin
         ex_valid_q <= 1'b0;
      end else if (accept) begin
         ex_valid_q <= 1'b1;
         op1_q      <= dec_op1;
         op2_q      <= dec_op2;
         opc_q      <= dec_op;
         rd_q       <= rd;
         rd_we_q    <= legal && (rd != 5'd0);
         pc_q       <= bus.pc_i;
         illegal_q  <= !legal;
      end else if (bus.ex_ready_i) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign bus.ready_o      = ready;
   assign bus.ex_valid_o   = ex_valid_q;
   assign bus.alu_op1_o    = op1_q;
   assign bus.alu_op2_o    = op2_q;
   assign bus.alu_opcode_o = opc_q;
   assign bus.rd_o         = rd_q;
   assign bus.rd_we_o      = rd_we_q;
   assign bus.pc_o         = pc_q;
   assign bus.illegal_o    = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - vector table, corner-case sequences and randomized model check of decode_stage
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   decode_stage_if bus ();

   decode_stage #(.FORWARD_EN(1'b1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] instr, pc, r1, r2;
      logic        wwe;
      logic [4:0]  wrd;
      logic [31:0] wdata;
      logic [31:0] op1, op2;
      logic [3:0]  opc;
      logic [4:0]  rd;
      logic        we, ill;
   } vec_t;

   typedef struct {
      logic [31:0] op1, op2;
      logic [3:0]  opc;
      logic [4:0]  rd;
      logic        we, ill;
   } exp_t;

   vec_t vt[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_slot(input string tag, input logic valid, input exp_t e, input logic [31:0] pc);
      chk({tag, ".ex_valid"}, 32'(bus.ex_valid_o), 32'(valid));
      chk({tag, ".op1"}, bus.alu_op1_o, e.op1);
      chk({tag, ".op2"}, bus.alu_op2_o, e.op2);
      chk({tag, ".opcode"}, 32'(bus.alu_opcode_o), 32'(e.opc));
      chk({tag, ".rd"}, 32'(bus.rd_o), 32'(e.rd));
      chk({tag, ".rd_we"}, 32'(bus.rd_we_o), 32'(e.we));
      chk({tag, ".illegal"}, 32'(bus.illegal_o), 32'(e.ill));
      chk({tag, ".pc"}, bus.pc_o, pc);
   endtask

   function automatic exp_t vexp(input vec_t v);
      exp_t e;
      e.op1 = v.op1; e.op2 = v.op2; e.opc = v.opc;
      e.rd  = v.rd;  e.we  = v.we;  e.ill = v.ill;
      return e;
   endfunction

   task automatic drive(input vec_t v, input logic valid, input logic exr, input logic fl);
      bus.instr_i       = v.instr;
      bus.pc_i          = v.pc;
      bus.rs1_data_i    = v.r1;
      bus.rs2_data_i    = v.r2;
      bus.wb_we_i       = v.wwe;
      bus.wb_rd_i       = v.wrd;
      bus.wb_data_i     = v.wdata;
      bus.instr_valid_i = valid;
      bus.ex_ready_i    = exr;
      bus.flush_i       = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // {funct7, funct3} -> ALU code as listed in the RV32I base table; -1 when undefined
   function automatic int op_table(input logic [9:0] k);
      case (k)
         {7'h00, 3'd0}: return 0;
         {7'h00, 3'd1}: return 5;
         {7'h00, 3'd2}: return 8;
         {7'h00, 3'd3}: return 9;
         {7'h00, 3'd4}: return 2;
         {7'h00, 3'd5}: return 6;
         {7'h00, 3'd6}: return 3;
         {7'h00, 3'd7}: return 4;
         {7'h20, 3'd0}: return 1;
         {7'h20, 3'd5}: return 7;
         default:       return -1;
      endcase
   endfunction

   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic we, input logic [4:0] wrd, input logic [31:0] wd);
      exp_t        e;
      int          code, simm;
      logic [31:0] s1, s2;
      logic [4:0]  a1, a2;
      logic [2:0]  f3;
      a1 = ins[19:15];
      a2 = ins[24:20];
      f3 = ins[14:12];
      s1 = (we && wrd == a1 && a1 != 0) ? wd : r1;
      s2 = (we && wrd == a2 && a2 != 0) ? wd : r2;
      e.rd  = ins[11:7];
      e.op1 = 0;
      e.op2 = 0;
      code  = -1;
      case (ins[6:0])
         7'h33: begin
            code  = op_table({ins[31:25], f3});
            e.op1 = s1;
            e.op2 = s2;
         end
         7'h13: begin
            e.op1 = s1;
            if (f3 == 3'd1 || f3 == 3'd5) begin
               code  = op_table({ins[31:25], f3});
               e.op2 = 32'(ins[24:20]);
            end else begin
               code = op_table({7'h00, f3});
               simm = int'(ins[31:20]);
               if (simm >= 2048) simm = simm - 4096;
               e.op2 = 32'(simm);
            end
         end
         7'h37: begin
            code  = 0;
            e.op2 = ins & 32'hFFFF_F000;
         end
         7'h17: begin
            code  = 0;
            e.op1 = pc;
            e.op2 = ins & 32'hFFFF_F000;
         end
         default: code = -1;
      endcase
      if (code < 0) begin
         e.ill = 1; e.we = 0; e.opc = 0; e.op1 = 0; e.op2 = 0;
      end else begin
         e.ill = 0; e.opc = 4'(code); e.we = (e.rd != 0);
      end
      return e;
   endfunction

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      logic [6:0]  f7s[3];
      r = $urandom;
      f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'($urandom);
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
         0: begin r[6:0] = 7'h33; r[31:25] = f7s[$urandom_range(0, 2)]; end
         1, 2: begin r[6:0] = 7'h13; r[31:25] = f7s[$urandom_range(0, 2)]; end
         3: r[6:0] = 7'h37;
         4: r[6:0] = 7'h17;
         default: r = $urandom;
      endcase
      return r;
   endfunction

   exp_t zero_e;
   vec_t idle_v;

   initial begin
      vt[0]  = '{32'hFFD08293, 32'h1000, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'hFFFFFFFD, 4'd0, 5'd5, 1'b1, 1'b0};
      vt[1]  = '{32'h402081B3, 32'h1004, 32'd7, 32'd9, 1'b0, 5'd0, 32'd0, 32'd7, 32'd9, 4'd1, 5'd3, 1'b1, 1'b0};
      vt[2]  = '{32'h41F25213, 32'h1008, 32'h80000000, 32'd0, 1'b0, 5'd0, 32'd0, 32'h80000000, 32'd31, 4'd7, 5'd4, 1'b1, 1'b0};
      vt[3]  = '{32'h123453B7, 32'h100C, 32'h55, 32'h66, 1'b0, 5'd0, 32'd0, 32'd0, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0};
      vt[4]  = '{32'h002081B3, 32'h1010, 32'd0, 32'd5, 1'b1, 5'd1, 32'h1234, 32'h1234, 32'd5, 4'd0, 5'd3, 1'b1, 1'b0};
      vt[5]  = '{32'h002001B3, 32'h1014, 32'd0, 32'd5, 1'b1, 5'd0, 32'h1234, 32'd0, 32'd5, 4'd0, 5'd3, 1'b1, 1'b0};
      vt[6]  = '{32'hFFFFFFFF, 32'h1018, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd31, 1'b0, 1'b1};
      vt[7]  = '{32'h022081B3, 32'h101C, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd3, 1'b0, 1'b1};
      vt[8]  = '{32'h00001097, 32'h0100, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h100, 32'h1000, 4'd0, 5'd1, 1'b1, 1'b0};
      vt[9]  = '{32'h00000013, 32'h0104, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0};
      vt[10] = '{32'h40109093, 32'h0108, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd1, 1'b0, 1'b1};
      vt[11] = '{32'h007332B3, 32'h010C, 32'h77, 32'd1, 1'b1, 5'd7, 32'hAA, 32'h77, 32'hAA, 4'd9, 5'd5, 1'b1, 1'b0};
      vt[12] = '{32'h002081B3, 32'h0110, 32'd4, 32'd5, 1'b0, 5'd1, 32'h99, 32'd4, 32'd5, 4'd0, 5'd3, 1'b1, 1'b0};
      zero_e = '{32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0};
      idle_v = '{32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0, 1'b0};

      drive(vt[0], 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      step();
      chk_slot("reset", 1'b0, zero_e, 32'd0);
      rst = 1'b0;
      drive(idle_v, 1'b0, 1'b0, 1'b0);
      #1;
      chk("reset.ready", 32'(bus.ready_o), 32'd1);

      for (int i = 0; i < 13; i++) begin
         drive(vt[i], 1'b1, 1'b1, 1'b0);
         #1;
         chk($sformatf("vec%0d.rs1_addr", i), 32'(bus.rs1_addr_o), 32'(vt[i].instr[19:15]));
         chk($sformatf("vec%0d.rs2_addr", i), 32'(bus.rs2_addr_o), 32'(vt[i].instr[24:20]));
         step();
         chk_slot($sformatf("vec%0d", i), 1'b1, vexp(vt[i]), vt[i].pc);
      end

      // Backpressure: hold A for three stalled cycles, then B issues back-to-back
      drive(vt[0], 1'b1, 1'b1, 1'b0);
      step();
      drive(vt[1], 1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d.ready", c), 32'(bus.ready_o), 32'd0);
         step();
         chk_slot($sformatf("stall%0d", c), 1'b1, vexp(vt[0]), vt[0].pc);
      end
      bus.ex_ready_i = 1'b1;
      #1;
      chk("unstall.ready", 32'(bus.ready_o), 32'd1);
      step();
      chk_slot("unstall", 1'b1, vexp(vt[1]), vt[1].pc);
      drive(vt[2], 1'b0, 1'b1, 1'b0);
      step();
      chk_slot("release", 1'b0, vexp(vt[1]), vt[1].pc);

      // Flush during a stall with a new instruction offered
      drive(vt[0], 1'b1, 1'b1, 1'b0);
      step();
      drive(vt[3], 1'b1, 1'b0, 1'b1);
      step();
      chk_slot("flush", 1'b0, vexp(vt[0]), vt[0].pc);
      drive(vt[3], 1'b0, 1'b0, 1'b0);
      step();
      chk_slot("post_flush", 1'b0, vexp(vt[0]), vt[0].pc);

      // Reset asserted while stalled
      drive(vt[3], 1'b1, 1'b1, 1'b0);
      step();
      drive(vt[1], 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      chk_slot("rst_stall", 1'b0, zero_e, 32'd0);
      rst = 1'b0;

      // Randomized traffic against the slot model
      begin
         logic        m_valid, n_valid, m_ready, rv, rr, rf;
         exp_t        m_e, n_e;
         logic [31:0] m_pc, n_pc;
         vec_t        v;
         m_valid = 0; m_e = zero_e; m_pc = 0;
         for (int c = 0; c < 600; c++) begin
            v = idle_v;
            v.instr = rnd_instr();
            v.pc    = $urandom;
            v.r1    = $urandom;
            v.r2    = $urandom;
            v.wwe   = 1'($urandom_range(0, 1));
            v.wrd   = 5'($urandom_range(0, 7));
            v.wdata = $urandom;
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            rf = ($urandom_range(0, 15) == 0);
            drive(v, rv, rr, rf);
            #1;
            m_ready = !m_valid || rr;
            chk($sformatf("rnd%0d.ready", c), 32'(bus.ready_o), 32'(m_ready));
            n_valid = m_valid; n_e = m_e; n_pc = m_pc;
            if (rf) begin
               n_valid = 0;
            end else if (rv && m_ready) begin
               n_valid = 1;
               n_e  = ref_decode(v.instr, v.pc, v.r1, v.r2, v.wwe, v.wrd, v.wdata);
               n_pc = v.pc;
            end else if (rr) begin
               n_valid = 0;
            end
            step();
            m_valid = n_valid; m_e = n_e; m_pc = n_pc;
            chk_slot($sformatf("rnd%0d", c), m_valid, m_e, m_pc);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
